// File: rtl/dmc_dma_pkg.sv
// dmc_dma_pkg: shared types and constants for the DMC DMA responder.
// Holds the FSM state encoding and the fetch cycle-count constants.
package dmc_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    DUMMY,
    ALIGN,
    READ,
    RELEASE
  } state_t;

  localparam logic ADDR_MSB_DEF       = 1'b1;
  localparam int   MAX_WRITE_WAIT_DEF = 3;

  // CPU cycles from the request being seen to the ack
  localparam int LAT_ALIGNED    = 3;
  localparam int LAT_MISALIGNED = 4;
  localparam int MIN_ACK_GAP    = 4;

endpackage

// File: rtl/dmc_dma_responder.sv
// dmc_dma_responder: halts the CPU, steals cycles and fetches one DMC byte.
// Optional macro DMC_DMA_DUMMY_READ_EN replays the CPU's read in DUMMY/ALIGN.
module dmc_dma_responder
  import dmc_dma_pkg::*;
#(
  parameter logic ADDR_MSB       = ADDR_MSB_DEF,
  parameter int   MAX_WRITE_WAIT = MAX_WRITE_WAIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_clk,
  input  logic        apu_phase,
  input  logic        cpu_r_nw,
  input  logic [15:0] cpu_addr,
  input  logic        dma_req,
  input  logic [14:0] dma_address,
  input  logic [7:0]  mem_data,
  output logic        cpu_rdy,
  output logic        bus_sel,
  output logic [15:0] bus_addr,
  output logic        dma_ack,
  output logic [7:0]  from_mem,
  output logic        err
);

  localparam int WW = $clog2(MAX_WRITE_WAIT + 2);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WRITE_WAIT);
  localparam logic [WW-1:0] WSAT = WMAX + 1'b1;

  state_t        state;
  state_t        state_nxt;
  logic [WW-1:0] wcnt;
  logic [WW-1:0] wcnt_nxt;
  logic          rdy_nxt;
  logic          err_nxt;
  logic          ack_nxt;
  logic [7:0]    data_nxt;

`ifndef DMC_DMA_DUMMY_READ_EN
  logic unused_cpu_addr;
  assign unused_cpu_addr = ^cpu_addr;
`endif

  // State, handshake and capture registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cpu_rdy  <= 1'b1;
      wcnt     <= '0;
      err      <= 1'b0;
      dma_ack  <= 1'b0;
      from_mem <= 8'h00;
    end else begin
      state    <= state_nxt;
      cpu_rdy  <= rdy_nxt;
      wcnt     <= wcnt_nxt;
      err      <= err_nxt;
      dma_ack  <= ack_nxt;
      from_mem <= data_nxt;
    end
  end

  // Next state, bus ownership and register updates
  always_comb begin
    state_nxt = state;
    rdy_nxt   = cpu_rdy;
    wcnt_nxt  = wcnt;
    err_nxt   = err;
    ack_nxt   = 1'b0;
    data_nxt  = from_mem;
    bus_sel   = 1'b0;
    bus_addr  = 16'h0000;
    unique case (state)
      IDLE: begin
        if (cpu_clk && dma_req) begin
          state_nxt = HALT;
          rdy_nxt   = 1'b0;
          wcnt_nxt  = '0;
        end
      end
      HALT: begin
        if (cpu_clk) begin
          if (!dma_req) begin
            state_nxt = IDLE;
            rdy_nxt   = 1'b1;
          end else if (!cpu_r_nw) begin
            if (wcnt != WSAT)
              wcnt_nxt = wcnt + 1'b1;
            if (wcnt >= WMAX)
              err_nxt = 1'b1;
          end else begin
            state_nxt = DUMMY;
          end
        end
      end
      DUMMY: begin
`ifdef DMC_DMA_DUMMY_READ_EN
        bus_sel  = 1'b1;
        bus_addr = cpu_addr;
`endif
        if (cpu_clk) begin
          if (!dma_req) begin
            state_nxt = IDLE;
            rdy_nxt   = 1'b1;
          end else begin
            state_nxt = apu_phase ? READ : ALIGN;
          end
        end
      end
      ALIGN: begin
`ifdef DMC_DMA_DUMMY_READ_EN
        bus_sel  = 1'b1;
        bus_addr = cpu_addr;
`endif
        if (cpu_clk) begin
          if (!dma_req) begin
            state_nxt = IDLE;
            rdy_nxt   = 1'b1;
          end else begin
            state_nxt = READ;
          end
        end
      end
      READ: begin
        bus_sel  = 1'b1;
        bus_addr = {ADDR_MSB, dma_address};
        if (cpu_clk) begin
          data_nxt  = mem_data;
          ack_nxt   = 1'b1;
          rdy_nxt   = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (cpu_clk)
          state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmc_dma_responder.sv
// tb_dmc_dma_responder: directed and random fetches against a
// transaction-level model of the DMC DMA responder.
module tb_dmc_dma_responder;
  import dmc_dma_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_clk = 1'b0;
  logic        apu_phase = 1'b0;
  logic        cpu_r_nw = 1'b1;
  logic [15:0] cpu_addr = 16'h0;
  logic        dma_req = 1'b0;
  logic [14:0] dma_address = 15'h0;
  logic [7:0]  mem_data = 8'h0;
  logic        cpu_rdy;
  logic        bus_sel;
  logic [15:0] bus_addr;
  logic        dma_ack;
  logic [7:0]  from_mem;
  logic        err;

  int checks = 0;
  int errors = 0;

  dmc_dma_responder dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_clk    (cpu_clk),
    .apu_phase  (apu_phase),
    .cpu_r_nw   (cpu_r_nw),
    .cpu_addr   (cpu_addr),
    .dma_req    (dma_req),
    .dma_address(dma_address),
    .mem_data   (mem_data),
    .cpu_rdy    (cpu_rdy),
    .bus_sel    (bus_sel),
    .bus_addr   (bus_addr),
    .dma_ack    (dma_ack),
    .from_mem   (from_mem),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: where the transfer is, in CPU cycles
  bit         m_busy  = 0;
  bit         m_halt  = 0;
  bit         m_cool  = 0;
  bit         m_extra = 0;
  bit         m_rdy   = 1;
  bit         m_err   = 0;
  bit         m_ack   = 0;
  int         m_n     = 0;
  int         m_w     = 0;
  logic [7:0] m_data  = 8'h0;

  task automatic m_reset();
    m_busy = 0; m_halt = 0; m_cool = 0; m_extra = 0;
    m_rdy = 1; m_err = 0; m_ack = 0; m_n = 0; m_w = 0;
    m_data = 8'h0;
  endtask

  task automatic m_abort();
    m_busy = 0;
    m_rdy  = 1;
  endtask

  task automatic m_cpu();
    if (m_cool) begin
      m_cool = 0;
    end else if (!m_busy) begin
      if (dma_req) begin
        m_busy = 1; m_halt = 0; m_w = 0; m_rdy = 0;
      end
    end else if (!m_halt) begin
      if (!dma_req) m_abort();
      else if (!cpu_r_nw) begin
        m_w++;
        if (m_w > MAX_WRITE_WAIT_DEF) m_err = 1;
      end else begin
        m_halt = 1; m_n = 0;
      end
    end else if (m_n == 1 + int'(m_extra)) begin
      m_ack = 1; m_data = mem_data; m_rdy = 1;
      m_cool = 1; m_busy = 0;
    end else if (!dma_req) begin
      m_abort();
    end else if (m_n == 0) begin
      m_extra = !apu_phase; m_n = 1;
    end else begin
      m_n = 2;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) m_reset();
      else begin
        m_ack = 0;
        if (cpu_clk) m_cpu();
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    int         lim;
    bit         rd;
    bit         win;
    logic       es;
    logic [15:0] ea;
    lim = 1 + int'(m_extra);
    rd  = m_busy && m_halt && (m_n == lim);
    win = m_busy && m_halt && (m_n < lim);
    es  = rd;
    ea  = rd ? {1'b1, dma_address} : 16'h0;
`ifdef DMC_DMA_DUMMY_READ_EN
    if (win) begin
      es = 1'b1;
      ea = cpu_addr;
    end
`else
    if (win) es = 1'b0;
`endif
    chk("m_cpu_rdy", int'(cpu_rdy), int'(m_rdy));
    chk("m_bus_sel", int'(bus_sel), int'(es));
    chk("m_bus_addr", int'(bus_addr), int'(ea));
    chk("m_dma_ack", int'(dma_ack), int'(m_ack));
    chk("m_from_mem", int'(from_mem), int'(m_data));
    chk("m_err", int'(err), int'(m_err));
  end

  // One CPU cycle: two plain clks then one cpu_clk clk
  task automatic step(input logic req, input logic rnw,
                      input logic ph);
    dma_req = req; cpu_r_nw = rnw; apu_phase = ph;
    cpu_clk = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    cpu_clk = 1'b1;
    @(posedge clk); #1;
    cpu_clk = 1'b0;
  endtask

  task automatic xfer(input string nm, input int nw,
                      input logic ph, input int exp_lat,
                      input logic [7:0] d);
    int   lat;
    logic ls;
    logic [15:0] la;
    mem_data = d;
    step(1'b1, 1'b1, ph);
    lat = 0; ls = 0; la = 0;
    for (int k = 0; k < 12; k++) begin
      ls = bus_sel; la = bus_addr;
      step(1'b1, (k < nw) ? 1'b0 : 1'b1, ph);
      lat++;
      if (dma_ack) break;
    end
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_ack"}, int'(dma_ack), 1);
    chk({nm, "_rd_sel"}, int'(ls), 1);
    chk({nm, "_rd_addr"}, int'(la), 32'hC000);
    chk({nm, "_data"}, int'(from_mem), int'(d));
    chk({nm, "_rdy"}, int'(cpu_rdy), 1);
    step(1'b0, 1'b1, ph);
    chk({nm, "_ack_once"}, int'(dma_ack), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int acks;
    int last;
    bit gap_ok;
    logic r;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", int'(cpu_rdy), 1);
    chk("rst_sel", int'(bus_sel), 0);
    chk("rst_addr", int'(bus_addr), 0);
    chk("rst_ack", int'(dma_ack), 0);
    chk("rst_data", int'(from_mem), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b1;
    dma_address = 15'h4000;
    cpu_addr = 16'h1234;

    xfer("aligned", 0, 1'b1, 3, 8'hA5);
    xfer("misalign", 0, 1'b0, 4, 8'h5A);
    xfer("wr2", 2, 1'b1, 5, 8'h3C);
    chk("wr2_err", int'(err), 0);
    xfer("wr4", 4, 1'b1, 7, 8'hC3);
    chk("wr4_err", int'(err), 1);
    do_reset();
    chk("err_clr", int'(err), 0);

    cpu_addr = 16'h2002;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
`ifdef DMC_DMA_DUMMY_READ_EN
    chk("dummy_sel", int'(bus_sel), 1);
    chk("dummy_addr", int'(bus_addr), 32'h2002);
`else
    chk("dummy_sel", int'(bus_sel), 0);
    chk("dummy_addr", int'(bus_addr), 0);
`endif
    chk("dummy_rdy", int'(cpu_rdy), 0);
    step(1'b0, 1'b1, 1'b1);
    chk("abort_rdy", int'(cpu_rdy), 1);
    chk("abort_ack", int'(dma_ack), 0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b1);
      chk("abort_noack", int'(dma_ack), 0);
    end

    mem_data = 8'h77;
    acks = 0; last = -100; gap_ok = 1;
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b1, 1'b1);
      if (dma_ack) begin
        if (k - last < MIN_ACK_GAP) gap_ok = 0;
        last = k;
        acks++;
      end
    end
    chk("b2b_acks", acks, 3);
    chk("b2b_gap", int'(gap_ok), 1);
    step(1'b0, 1'b1, 1'b1);

    mem_data = 8'h99;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("pre_rst_sel", int'(bus_sel), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_rdy", int'(cpu_rdy), 1);
    chk("mid_rst_sel", int'(bus_sel), 0);
    chk("mid_rst_addr", int'(bus_addr), 0);
    chk("mid_rst_ack", int'(dma_ack), 0);
    chk("mid_rst_data", int'(from_mem), 0);
    chk("mid_rst_err", int'(err), 0);
    dma_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    r = 1'b0;
    for (int k = 0; k < 400; k++) begin
      dma_address = 15'($urandom);
      cpu_addr = 16'($urandom);
      mem_data = 8'($urandom);
      if (!r) r = ($urandom % 3) == 0;
      else if (dma_ack) r = ($urandom % 2) == 0;
      else if (($urandom % 12) == 0) r = 1'b0;
      step(r, ($urandom % 4) != 0, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmc_dma_responder.md
Name: dmc_dma_responder

Overview:
- Memory-side responder for the APU DMC sample-fetch request (dma_req/dma_address/dma_ack/from_mem).
- Stalls the CPU via RDY, steals 3-4 CPU cycles and reads one byte at {1'b1, dma_address}.
- Returns the byte with a single-clk acknowledge.
- Sits between the CPU core, the system bus mux and the APU in the CPU subsystem.

Parameters:
- ADDR_MSB, 1'b1, value forced onto bus_addr[15] during the DMA read (DMC samples live at $8000-$FFFF).
- MAX_WRITE_WAIT, 3, maximum consecutive CPU write cycles tolerated before halt; exceeding it is a protocol error.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- cpu_clk  input  1  one-clk enable marking each CPU cycle boundary
- apu_phase  input  1  1 = current CPU cycle is a "get" (read-aligned) cycle; 0 = "put"
- cpu_r_nw  input  1  read/write of the CPU's current cycle
- cpu_addr  input  16  CPU's current address
- dma_req  input  1  level request from the APU; held until dma_ack
- dma_address  input  15  sample address from the APU
- mem_data  input  8  bus read data
- cpu_rdy  output  1  0 halts the CPU on its next read cycle
- bus_sel  output  1  1 = responder owns the address bus
- bus_addr  output  16  responder-driven address, valid when bus_sel=1
- dma_ack  output  1  one-clk pulse; from_mem valid from this cycle on
- from_mem  output  8  fetched sample byte, held until the next ack
- err  output  1  sticky; set when the write wait exceeds MAX_WRITE_WAIT

Behaviour:
- Reset (rst=0, async): state IDLE; cpu_rdy=1, bus_sel=0, bus_addr=0, dma_ack=0, from_mem=0, err=0, write counter=0.
- All state advances occur only on clks with cpu_clk=1, except dma_ack and from_mem, which update on the clk of the READ-state cpu_clk.
- IDLE: on cpu_clk with dma_req=1 -> HALT; cpu_rdy<=0.
- HALT: the CPU cycle in progress completes.
  - On cpu_clk, if cpu_r_nw=0 (a write, which cannot be halted): stay, increment the write counter; counter>MAX_WRITE_WAIT sets err.
  - If cpu_r_nw=1: CPU halted -> DUMMY.
- DUMMY: bus_sel=0, so the CPU's repeated read occurs harmlessly.
  - On cpu_clk: apu_phase=1 -> READ, else -> ALIGN.
- ALIGN: one extra idle cycle -> READ.
- READ: bus_sel=1, bus_addr={ADDR_MSB, dma_address}.
  - On cpu_clk: capture mem_data into from_mem, pulse dma_ack, -> RELEASE.
- RELEASE: bus_sel=0, cpu_rdy<=1 on entry; dma_req is ignored until the next cpu_clk, so a request still high after ack is not re-serviced. Then -> IDLE.
- Latency, req to ack, with the CPU reading: 3 CPU cycles if aligned, 4 if not; each prior CPU write adds 1.
- Back-to-back: a req seen on the first cpu_clk in IDLE after RELEASE starts a new transfer; minimum gap between acks is 4 CPU cycles.
- dma_req dropping before ack: abort at the next cpu_clk, return to IDLE, restore cpu_rdy=1, no ack. Exception: in READ, the fetch completes anyway.
- dma_address is sampled combinationally during READ only; changes in earlier states are tolerated.
- Reset mid-transfer releases the bus and the CPU immediately; no ack is issued.

Optional Feature:
- Macro: DMC_DMA_DUMMY_READ_EN.
- Defined: in DUMMY and ALIGN the responder owns the bus (bus_sel=1) and drives bus_addr=cpu_addr. This reproduces the hardware's repeated CPU reads, which have register side effects at $2002/$2007/$4016.
- Undefined: bus_sel=0 in those states and no extra read is issued.

Decomposition:
- Shared package dmc_dma_pkg holds:
  - state enum IDLE/HALT/DUMMY/ALIGN/READ/RELEASE
  - ADDR_MSB default
  - the cycle-count constants used by the bench
- No sub-module; a single FSM plus capture register.

Test Plan:
- Aligned fetch: CPU reading, apu_phase=1 at DUMMY exit, dma_address=15'h4000, mem_data=8'hA5 -> bus_addr=16'hC000 in READ, dma_ack after 3 cpu_clk, from_mem=8'hA5, cpu_rdy back to 1.
- Misaligned fetch: same stimulus with apu_phase=0 -> one ALIGN cycle, ack after 4 cpu_clk.
- Write stall: req arrives during 2 consecutive CPU writes -> HALT held 2 extra cycles, ack after 5 cpu_clk, err=0. With 4 writes -> err=1.
- Back-to-back: req held high across ack -> exactly one ack per transfer, second ack no earlier than 4 CPU cycles after the first.
- Abort/reset: req dropped in DUMMY -> no ack, cpu_rdy=1 next cpu_clk. rst=0 in READ -> all outputs at reset values immediately.
- With DMC_DMA_DUMMY_READ_EN, cpu_addr=16'h2002 -> bus_sel=1, bus_addr=16'h2002 during DUMMY; without the macro bus_sel=0.
